pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor, successor to the team's fixed 32-bit two-block CLA. Operand width is split into NSEG equal segments, one segment per pipeline stage, with the carry registered between stages. Valid/ready handshakes on input and output give one result per cycle with backpressure. Adds a subtract mode and cout/overflow/zero flags. Sits in the datapath wherever a wide adder must meet timing at high clock rates.

---
 rtl/pipelined_cla_adder.sv | 133 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit CLA segment per stage,
// carry registered between stages, single global advance for valid/ready flow control.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_W;

    logic adv_s;
    logic ovf_r;
    logic zero_r;

    // Returns {carry into segment MSB, carry out, segment sum}; every carry is a
    // flat generate/propagate lookahead term rather than a ripple chain.
    function automatic logic [SEG_W+1:0] cla_seg(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             c0
    );
        logic [SEG_W-1:0] g;
        logic [SEG_W-1:0] p;
        logic [SEG_W-1:0] s;
        logic [SEG_W:0]   c;
        logic             acc;
        logic             pp;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        for (int i = 0; i < SEG_W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & c0);
        end
        s = p ^ c[SEG_W-1:0];
        return {c[SEG_W-1], c[SEG_W], s};
    endfunction

    assign adv_s    = ~out_valid | out_ready;
    assign in_ready = adv_s;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic             vld_r;
        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] b_r;
        logic [WIDTH-1:0] s_r;
        logic             c_r;
        logic             v_in_s;
        logic [WIDTH-1:0] a_in_s;
        logic [WIDTH-1:0] b_in_s;
        logic [WIDTH-1:0] s_in_s;
        logic             c_in_s;
        logic [SEG_W+1:0] cla_s;
        logic [WIDTH-1:0] s_nxt_s;
        logic             unused_s;

        if (k == 0) begin : g_head
            // Subtraction folds into the first stage as a + ~b + 1.
            assign v_in_s = in_valid;
            assign a_in_s = a;
            assign b_in_s = sub ? ~b : b;
            assign c_in_s = sub ? 1'b1 : cin;
            assign s_in_s = '0;
        end else begin : g_body
            assign v_in_s = g_stage[k-1].vld_r;
            assign a_in_s = g_stage[k-1].a_r;
            assign b_in_s = g_stage[k-1].b_r;
            assign c_in_s = g_stage[k-1].c_r;
            assign s_in_s = g_stage[k-1].s_r;
        end

        assign cla_s    = cla_seg(a_in_s[k*SEG_W +: SEG_W], b_in_s[k*SEG_W +: SEG_W], c_in_s);
        assign s_nxt_s  = s_in_s | (WIDTH'(cla_s[SEG_W-1:0]) << (k * SEG_W));
        assign unused_s = ^{a_r, b_r, cla_s[SEG_W+1]};

        // Stage register: valid moves on every advance, payload only with a real operation
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_r <= 1'b0;
                a_r   <= '0;
                b_r   <= '0;
                s_r   <= '0;
                c_r   <= 1'b0;
            end else if (adv_s) begin
                vld_r <= v_in_s;
                if (v_in_s) begin
                    a_r <= a_in_s;
                    b_r <= b_in_s;
                    s_r <= s_nxt_s;
                    c_r <= cla_s[SEG_W];
                end
            end
        end

        if (k == NSEG - 1) begin : g_tail
            // Result flags, loaded together with the final stage so they hold across bubbles
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (adv_s && v_in_s) begin
                    ovf_r  <= cla_s[SEG_W+1] ^ cla_s[SEG_W];
                    zero_r <= (s_nxt_s == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].vld_r;
    assign sum       = g_stage[NSEG-1].s_r;
    assign cout      = g_stage[NSEG-1].c_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: 32/8 main instance plus 64/16 and 32/32 builds.
module tb_pipelined_cla_adder;
    localparam int WIDTH = 32;
    localparam int SEG_W = 8;
    localparam int NSEG  = WIDTH / SEG_W;
    localparam int NV    = 12;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_cout, w_ovf, w_zero;
    logic [63:0] w_a, w_b, w_sum;
    logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_cout, n_ovf, n_zero;
    logic [31:0] n_a, n_b, n_sum;
    logic        x_out_ready;

    vec_t        vt [NV];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rdy_pat  = 16'b1011_0010_1100_1101;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(64), .SEG_W(16)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
        .out_valid(w_out_valid), .out_ready(x_out_ready),
        .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zero(w_zero)
    );

    pipelined_cla_adder #(.WIDTH(32), .SEG_W(32)) dut_n1 (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub),
        .out_valid(n_out_valid), .out_ready(x_out_ready),
        .sum(n_sum), .cout(n_cout), .ovf(n_ovf), .zero(n_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i);
        a   = vt[i].a;
        b   = vt[i].b;
        cin = vt[i].cin;
        sub = vt[i].sub;
    endtask

    task automatic drive_idle();
        a   = 32'hDEAD_BEEF;
        b   = 32'hFACE_0FF0;
        cin = 1'b1;
        sub = 1'b1;
    endtask

    // Streams vt[first .. first+n-1]; checks every visible result in order and,
    // without stalls, that each result arrives exactly NSEG cycles after its accept.
    task automatic run_stream(input int first, input int n, input bit stall);
        int   wr;
        int   rd;
        int   cyc;
        int   acc_cyc [NV];
        logic acc;
        logic drn;
        logic exp_rdy;
        vec_t e;
        wr  = 0;
        rd  = 0;
        cyc = 0;
        while (rd < n && cyc < 400) begin
            out_ready = stall ? rdy_pat[cyc % 16] : 1'b1;
            in_valid  = (wr < n);
            if (wr < n) drive(first + wr);
            else drive_idle();
            #1;
            exp_rdy = ~out_valid | out_ready;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (out_valid) begin
                if (rd < n) begin
                    e = vt[first + rd];
                    check("sum",  64'(sum),  64'(e.s));
                    check("cout", 64'(cout), 64'(e.co));
                    check("ovf",  64'(ovf),  64'(e.ov));
                    check("zero", 64'(zero), 64'(e.z));
                    if (drn && !stall) check("latency", 64'(cyc - acc_cyc[rd]), 64'(NSEG));
                end else begin
                    check("extra_out", 64'(out_valid), 64'd0);
                end
            end
            if (acc) acc_cyc[wr] = cyc;
            @(posedge clk);
            #1;
            if (acc) wr++;
            if (drn) rd++;
            cyc++;
        end
        in_valid = 1'b0;
        drive_idle();
        check("drained", 64'(rd), 64'(n));
    endtask

    task automatic run_w64(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                           input logic tc, input logic ts, input logic [63:0] es,
                           input logic eco, input logic eov, input logic ez);
        int lat;
        w_a = ta; w_b = tb; w_cin = tc; w_sub = ts; w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        w_a = 64'hDEAD_BEEF_DEAD_BEEF;
        lat = 1;
        while (!w_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"},  64'(lat), 64'd4);
        check({tag, "_sum"},  w_sum, es);
        check({tag, "_cout"}, 64'(w_cout), 64'(eco));
        check({tag, "_ovf"},  64'(w_ovf),  64'(eov));
        check({tag, "_zero"}, 64'(w_zero), 64'(ez));
    endtask

    task automatic run_n1(input int i);
        int lat;
        n_a = vt[i].a; n_b = vt[i].b; n_cin = vt[i].cin; n_sub = vt[i].sub; n_in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        n_a = 32'hDEAD_BEEF;
        lat = 1;
        while (!n_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("n1_lat",  64'(lat), 64'd1);
        check("n1_sum",  64'(n_sum), 64'(vt[i].s));
        check("n1_cout", 64'(n_cout), 64'(vt[i].co));
        check("n1_ovf",  64'(n_ovf),  64'(vt[i].ov));
        check("n1_zero", 64'(n_zero), 64'(vt[i].z));
    endtask

    initial begin
        vt[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{32'h0000_000A, 32'h0000_000A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0};
        vt[10] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vt[11] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0001_FFFF, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; drive_idle();
        w_in_valid = 1'b0; w_a = 64'd0; w_b = 64'd0; w_cin = 1'b0; w_sub = 1'b0;
        n_in_valid = 1'b0; n_a = 32'd0; n_b = 32'd0; n_cin = 1'b0; n_sub = 1'b0;
        x_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);

        run_stream(0, 1, 1'b0);
        run_stream(1, 2, 1'b0);
        run_stream(3, 1, 1'b0);
        run_stream(0, NV, 1'b0);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_sum_hold",  64'(sum),  64'(vt[NV-1].s));
        check("idle_zero_hold", 64'(zero), 64'(vt[NV-1].z));
        run_stream(0, NV, 1'b1);

        // Three operations in flight, then a one-cycle reset
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            drive(4 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum",       64'(sum),       64'd0);
        check("mid_rst_cout",      64'(cout),      64'd0);
        check("mid_rst_ovf",       64'(ovf),       64'd0);
        check("mid_rst_zero",      64'(zero),      64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        for (int i = 0; i < 6; i++) begin
            check("mid_rst_ghost", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        run_stream(3, 1, 1'b0);

        run_w64("w64_ripple", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_w64("w64_seg", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        run_w64("w64_sub", 64'd3, 64'd3, 1'b1, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1);
        run_n1(3);
        run_n1(2);
        run_n1(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
